// File: rtl/opc_piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on VALID/READY, shifts it out
// one bit per CLK with SEN framing and a DONE pulse on the last bit.
module opc_piso_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DIN,
    input  logic             VALID,
    output logic             READY,
    output logic             SOUT,
    output logic             SEN,
    output logic             DONE
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_n;
    logic [WIDTH-1:0] sreg_q,  sreg_n;
    logic [CW-1:0]    cnt_q,   cnt_n;
    logic             sout_q,  sout_n;
    logic             sen_q,   sen_n;
    logic             done_q,  done_n;
    logic             ready_q, ready_n;
    logic             xfer;

    // First bit to leave the word, according to bit order
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with the first bit consumed
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // The shift register holds the bits still to be sent; SOUT is registered
    // directly from the bit being consumed so the first bit appears right after the transfer edge.
    always_comb begin
        state_n = state_q;
        sreg_n  = sreg_q;
        cnt_n   = cnt_q;
        sout_n  = IDLE_LEVEL;
        xfer    = VALID && ready_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_n = ST_SHIFT;
                    cnt_n   = '0;
                    sout_n  = first_bit(DIN);
                    sreg_n  = shift_word(DIN);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST) begin
                    if (xfer) begin
                        cnt_n  = '0;
                        sout_n = first_bit(DIN);
                        sreg_n = shift_word(DIN);
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n  = cnt_q + CW'(1);
                    sout_n = first_bit(sreg_q);
                    sreg_n = shift_word(sreg_q);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        sen_n   = (state_n == ST_SHIFT);
        done_n  = sen_n && (cnt_n == LAST);
        ready_n = !sen_n || (cnt_n == LAST);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            sout_q  <= IDLE_LEVEL;
            sen_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_n;
            sreg_q  <= sreg_n;
            cnt_q   <= cnt_n;
            sout_q  <= sout_n;
            sen_q   <= sen_n;
            done_q  <= done_n;
            ready_q <= ready_n;
        end
    end

    assign READY = ready_q;
    assign SOUT  = sout_q;
    assign SEN   = sen_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_opc_piso_tx.sv
// Bench for opc_piso_tx: MSB-first and LSB-first instances in lockstep, bit scoreboards and
// a SEN-gated receive shift register for loopback.
module tb_opc_piso_tx;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] DIN;
    logic       VALID;
    logic       READY_m, SOUT_m, SEN_m, DONE_m;
    logic       READY_l, SOUT_l, SEN_l, DONE_l;

    int checks   = 0;
    int failures = 0;

    exp_t       qm[$];
    exp_t       ql[$];
    logic [7:0] qw[$];
    logic [7:0] rx;
    logic       lb_pend = 1'b0;

    always #5 CLK = ~CLK;

    opc_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .CLK(CLK), .RESET(RESET), .DIN(DIN), .VALID(VALID),
        .READY(READY_m), .SOUT(SOUT_m), .SEN(SEN_m), .DONE(DONE_m)
    );

    opc_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .CLK(CLK), .RESET(RESET), .DIN(DIN), .VALID(VALID),
        .READY(READY_l), .SOUT(SOUT_l), .SEN(SEN_l), .DONE(DONE_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver: positive-edge flops that sample SOUT while SEN is high
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) rx <= 8'h00;
        else if (SEN_m) rx <= {rx[6:0], SOUT_m};
    end

    // Scoreboard push on every handshake edge
    always @(posedge CLK) begin
        if (RESET && VALID && READY_m) begin
            for (int i = 0; i < 8; i++) qm.push_back('{b: DIN[7-i], last: (i == 7)});
            qw.push_back(DIN);
        end
        if (RESET && VALID && READY_l) begin
            for (int i = 0; i < 8; i++) ql.push_back('{b: DIN[i], last: (i == 7)});
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge CLK) begin
        logic       rdy_exp;
        exp_t       e;
        logic [7:0] w;
        if (!RESET) begin
            qm.delete();
            ql.delete();
            qw.delete();
            lb_pend = 1'b0;
        end else begin
            if (lb_pend) begin
                lb_pend = 1'b0;
                if (qw.size() != 0) begin
                    w = qw.pop_front();
                    chk("loopback_rx", 32'(rx), 32'(w));
                end else begin
                    chk("loopback_word_queue", 32'(qw.size()), 32'd1);
                end
            end
            rdy_exp = (qm.size() == 0) || qm[0].last;
            chk("ready_m", 32'(READY_m), 32'(rdy_exp));
            if (qm.size() != 0) begin
                e = qm.pop_front();
                chk("sen_m", 32'(SEN_m), 32'd1);
                chk("sout_m", 32'(SOUT_m), 32'(e.b));
                chk("done_m", 32'(DONE_m), 32'(e.last));
                if (e.last) lb_pend = 1'b1;
            end else begin
                chk("idle_sen_m", 32'(SEN_m), 32'd0);
                chk("idle_sout_m", 32'(SOUT_m), 32'd0);
                chk("idle_done_m", 32'(DONE_m), 32'd0);
            end
            rdy_exp = (ql.size() == 0) || ql[0].last;
            chk("ready_l", 32'(READY_l), 32'(rdy_exp));
            if (ql.size() != 0) begin
                e = ql.pop_front();
                chk("sen_l", 32'(SEN_l), 32'd1);
                chk("sout_l", 32'(SOUT_l), 32'(e.b));
                chk("done_l", 32'(DONE_l), 32'(e.last));
            end else begin
                chk("idle_sen_l", 32'(SEN_l), 32'd0);
                chk("idle_sout_l", 32'(SOUT_l), 32'd0);
                chk("idle_done_l", 32'(DONE_l), 32'd0);
            end
        end
    end

    // Present a word with VALID high until a handshake edge; VALID stays high afterwards
    task automatic send(input logic [7:0] w);
        logic ok;
        ok = 1'b0;
        @(negedge CLK);
        DIN   = w;
        VALID = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge CLK);
            ok = READY_m;
        end
        chk("handshake_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        VALID = 1'b0;
        DIN   = 8'h00;
        repeat (n - 1) @(negedge CLK);
    endtask

    initial begin
        int budget;
        RESET = 1'b0;
        VALID = 1'b0;
        DIN   = 8'h00;
        #2;
        chk("rst_sout", 32'(SOUT_m), 32'd0);
        chk("rst_sen", 32'(SEN_m), 32'd0);
        chk("rst_done", 32'(DONE_m), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_release_ready", 32'(READY_m), 32'd1);

        // Single word; DIN changes right after acceptance and VALID stays low after
        send(8'hA5);
        idle(12);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            #1;
            chk("idle5_sen", 32'(SEN_m), 32'd0);
            chk("idle5_sout", 32'(SOUT_m), 32'd0);
        end

        send(8'h01);
        idle(12);

        // Back-to-back with VALID held high
        send(8'hFF);
        send(8'h00);
        idle(12);

        // Reset in the middle of a word
        send(8'hC3);
        repeat (3) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("midrst_sout", 32'(SOUT_m), 32'd0);
        chk("midrst_sen", 32'(SEN_m), 32'd0);
        chk("midrst_done", 32'(DONE_m), 32'd0);
        chk("midrst_sen_l", 32'(SEN_l), 32'd0);
        VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("midrst_release_ready", 32'(READY_m), 32'd1);
        idle(4);

        send(8'h3C);
        idle(12);

        // Random words, mix of back-to-back and gaps
        for (int n = 0; n < 100; n++) begin
            send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        budget = 0;
        while ((qm.size() != 0 || ql.size() != 0 || lb_pend) && budget < 50) begin
            @(negedge CLK);
            budget++;
        end
        repeat (2) @(negedge CLK);
        chk("drain_msb", 32'(qm.size()), 32'd0);
        chk("drain_lsb", 32'(ql.size()), 32'd0);
        chk("drain_words", 32'(qw.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
